// File: rtl/logs_out_stage.sv
// Output conditioning for the sonifier PWM: windowed density measurement, slewed
// volume scaling and first-order sigma-delta re-modulation, with a mute state.
module logs_out_stage #(
  parameter int DEC_LOG2  = 5,
  parameter int VOL_BITS  = 4,
  parameter int FADE_LOG2 = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                snd_in,
  input  logic                enable,
  input  logic [VOL_BITS-1:0] vol_target,
  output logic                snd_out,
  output logic [DEC_LOG2:0]   level,
  output logic                fading,
  output logic                muted
);

  localparam int SD_W = DEC_LOG2 + VOL_BITS;
  localparam logic [DEC_LOG2-1:0]  WC_ONE  = 1;
  localparam logic [DEC_LOG2-1:0]  WC_LAST = '1;
  localparam logic [FADE_LOG2-1:0] FT_ONE  = 1;
  localparam logic [VOL_BITS-1:0]  VOL_ONE = 1;

  typedef enum logic [1:0] {IDLE, SLEW, STEADY} state_t;

  state_t              state, state_nxt;
  logic [DEC_LOG2-1:0] wcnt;
  logic [DEC_LOG2:0]   acc;
  logic [DEC_LOG2:0]   snd_ext;
  logic [VOL_BITS-1:0] goal;
  logic [VOL_BITS-1:0] cur_vol;
  logic [FADE_LOG2-1:0] ft;
  logic [SD_W-1:0]     sd;
  logic [SD_W:0]       prod;
  logic [SD_W:0]       sd_sum;

  function automatic logic [VOL_BITS-1:0] step_toward(input logic [VOL_BITS-1:0] v,
                                                      input logic [VOL_BITS-1:0] g);
    if (v < g) return v + VOL_ONE;
    if (v > g) return v - VOL_ONE;
    return v;
  endfunction

  assign goal    = enable ? vol_target : '0;
  assign snd_ext = {{DEC_LOG2{1'b0}}, snd_in};

  // Density: count ones over each 2^DEC_LOG2-cycle window, publish at the window end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt  <= '0;
      acc   <= '0;
      level <= '0;
    end else begin
      wcnt <= wcnt + WC_ONE;
      if (wcnt == WC_LAST) begin
        level <= acc + snd_ext;
        acc   <= '0;
      end else begin
        acc <= acc + snd_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (goal != '0) state_nxt = SLEW;
      SLEW:    if (cur_vol == goal) state_nxt = (goal == '0) ? IDLE : STEADY;
      STEADY:  if (goal != cur_vol) state_nxt = SLEW;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fading = (state == SLEW);
    muted  = (state == IDLE);
  end

  // Volume slew: a goal change mid-slew only redirects the next step, it keeps ft running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ft      <= '0;
      cur_vol <= '0;
    end else if (state != SLEW && state_nxt == SLEW) begin
      ft <= '0;
    end else if (state == SLEW) begin
      ft <= ft + FT_ONE;
      if (ft == '1) cur_vol <= step_toward(cur_vol, goal);
    end
  end

  // Modulator: carry out of the phase accumulator is the output bit
  assign prod   = {{VOL_BITS{1'b0}}, level} * {{(DEC_LOG2 + 1){1'b0}}, cur_vol};
  assign sd_sum = {1'b0, sd} + prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd      <= '0;
      snd_out <= 1'b0;
    end else if (state == IDLE || state_nxt == IDLE) begin
      sd      <= '0;
      snd_out <= 1'b0;
    end else begin
      sd      <= sd_sum[SD_W-1:0];
      snd_out <= sd_sum[SD_W];
    end
  end

endmodule

// File: tb/tb_logs_out_stage.sv
// Scoreboard bench for logs_out_stage: stimulus pushes expected level values,
// state transitions (with cycle stamps) and snd_out densities; monitors pop and compare.
module tb_logs_out_stage;

  localparam int DEC_LOG2  = 5;
  localparam int VOL_BITS  = 4;
  localparam int FADE_LOG2 = 4;
  localparam int W         = 1 << DEC_LOG2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                snd_in;
  logic                enable;
  logic [VOL_BITS-1:0] vol_target;
  logic                snd_out;
  logic [DEC_LOG2:0]   level;
  logic                fading;
  logic                muted;

  logs_out_stage #(.DEC_LOG2(DEC_LOG2), .VOL_BITS(VOL_BITS), .FADE_LOG2(FADE_LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .snd_in(snd_in), .enable(enable), .vol_target(vol_target),
    .snd_out(snd_out), .level(level), .fading(fading), .muted(muted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    fm;
    int    cyc;
    string name;
  } tr_t;

  typedef struct {
    int    lo;
    int    hi;
    int    n;
    string name;
  } dens_t;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    wpos;
  int    ones_cfg = 0;
  int    cur_ones = 0;
  bit    mon_on = 1'b0;
  int    prev_fm = 1;
  int    lvl_q[$];
  tr_t   trans_q[$];
  dens_t dens_q[$];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
    end
  endtask

  task automatic expect_tr(input int f, input int m, input int c, input string nm);
    tr_t t;
    t.fm = f * 2 + m;
    t.cyc = c;
    t.name = nm;
    trans_q.push_back(t);
  endtask

  task automatic expect_dens(input int lo, input int hi, input int n, input string nm);
    dens_t d;
    d.lo = lo;
    d.hi = hi;
    d.n = n;
    d.name = nm;
    dens_q.push_back(d);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wpos <= 0;
    else        wpos <= wpos + 1;
  end

  // snd_in driver: each window carries ones_cfg ones, latched at the window start
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        snd_in = 1'($urandom_range(0, 1));
      end else begin
        if (wpos % W == 0) begin
          cur_ones = ones_cfg;
          lvl_q.push_back(cur_ones);
        end
        snd_in = ((wpos % W) < cur_ones);
      end
    end
  end

  // level monitor: one completed window per W cycles after reset release
  always @(negedge clk) begin
    if (mon_on && rst_n && wpos > 0 && wpos % W == 0) begin
      if (lvl_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL level: no expectation queued, got %0d", level);
      end else begin
        chk("level", int'(level), lvl_q.pop_front());
      end
    end
  end

  // state monitor: fading/muted transitions and silence while muted
  always @(negedge clk) begin
    int fm;
    tr_t t;
    if (mon_on) begin
      fm = int'(fading) * 2 + int'(muted);
      if (muted) chk("mute_silent", int'(snd_out), 0);
      if (fm != prev_fm) begin
        if (trans_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transition: got fm=%0d from %0d at cycle %0d", fm, prev_fm, cyc);
        end else begin
          t = trans_q.pop_front();
          chk({t.name, "_state"}, fm, t.fm);
          chk({t.name, "_cycle"}, cyc, t.cyc);
        end
        prev_fm = fm;
      end
    end
  end

  // density monitor
  initial begin
    dens_t d;
    int cnt;
    forever begin
      wait (dens_q.size() > 0);
      d = dens_q.pop_front();
      cnt = 0;
      repeat (d.n) begin
        @(negedge clk);
        cnt += int'(snd_out);
      end
      chk_rng(d.name, cnt, d.lo, d.hi);
    end
  end

  initial begin
    int c;
    rst_n = 1'b1;
    snd_in = 1'b0;
    enable = 1'b0;
    vol_target = '0;
    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_snd_out", int'(snd_out), 0);
    chk("rst_muted", int'(muted), 1);
    chk("rst_fading", int'(fading), 0);
    chk("rst_level", int'(level), 0);
    mon_on = 1'b1;

    // idle with density patterns, 10 windows
    ones_cfg = 8;
    rst_n = 1'b1;
    repeat (3 * W) @(negedge clk);
    ones_cfg = 32;
    repeat (3 * W) @(negedge clk);
    ones_cfg = 0;
    repeat (2 * W) @(negedge clk);
    ones_cfg = 5;
    repeat (2 * W) @(negedge clk);

    // fade in to 15 with snd_in constant 1
    ones_cfg = 32;
    c = cyc;
    vol_target = 4'd15;
    enable = 1'b1;
    expect_tr(1, 0, c + 1, "slew_in");
    expect_tr(0, 0, c + 242, "steady15");
    repeat (245) @(negedge clk);
    expect_dens(959, 961, 1024, "dens15");
    repeat (1030) @(negedge clk);

    // fade out to idle
    c = cyc;
    enable = 1'b0;
    expect_tr(1, 0, c + 1, "slew_out");
    expect_tr(0, 1, c + 242, "idle_out");
    repeat (250) @(negedge clk);
    chk("sd_cleared", int'(dut.sd), 0);
    expect_dens(0, 0, 64, "dens_idle");
    repeat (70) @(negedge clk);

    // target change mid-slew at cur_vol 6 (ft keeps running)
    c = cyc;
    vol_target = 4'd15;
    enable = 1'b1;
    expect_tr(1, 0, c + 1, "slew_in2");
    expect_tr(0, 0, c + 146, "steady3");
    repeat (100) @(negedge clk);
    vol_target = 4'd3;
    repeat (50) @(negedge clk);
    expect_dens(191, 193, 1024, "dens3");
    repeat (1030) @(negedge clk);

    // target change from STEADY
    c = cyc;
    vol_target = 4'd5;
    expect_tr(1, 0, c + 1, "slew_up5");
    expect_tr(0, 0, c + 34, "steady5");
    repeat (40) @(negedge clk);
    expect_dens(319, 321, 1024, "dens5");
    repeat (1030) @(negedge clk);

    // vol_target 0 with enable high fades to idle and stays there
    c = cyc;
    vol_target = 4'd0;
    expect_tr(1, 0, c + 1, "slew_down0");
    expect_tr(0, 1, c + 82, "idle_vt0");
    repeat (90) @(negedge clk);
    repeat (40) @(negedge clk);
    chk("idle_hold_vt0", int'(muted), 1);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_hold_dis", int'(muted), 1);

    // asynchronous reset during SLEW
    c = cyc;
    vol_target = 4'd15;
    enable = 1'b1;
    expect_tr(1, 0, c + 1, "slew_pre_rst");
    repeat (50) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    lvl_q.delete();
    expect_tr(0, 1, cyc, "async_rst");
    #1;
    chk("arst_fading", int'(fading), 0);
    chk("arst_muted", int'(muted), 1);
    chk("arst_snd_out", int'(snd_out), 0);
    chk("arst_level", int'(level), 0);
    enable = 1'b0;
    ones_cfg = 8;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * W + 4) @(negedge clk);
    chk("post_rst_muted", int'(muted), 1);

    chk("transitions_left", trans_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logs_out_stage.md
# logs_out_stage

Output conditioning stage placed directly downstream of the logistic-map sonifier's 1-bit PWM `snd`, ahead of the audio pin. It measures the density of the incoming PWM over fixed windows, scales it by a volume that slews toward a target (click-free fade-in/out on enable), and re-modulates the result with a first-order sigma-delta modulator. A mute state forces silence and clears all modulator history.

## Interface
- `DEC_LOG2`, default 5: log2 of the density-measurement window length in cycles (W = 2^DEC_LOG2).
- `VOL_BITS`, default 4: width of the volume value.
- `FADE_LOG2`, default 14: log2 of the number of cycles per one-LSB volume step while slewing.

- `clk`  in  1  clock. This is the block's only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `snd_in`  in  1  PWM audio from the sonifier.
- `enable`  in  1  1 = play at `vol_target`; 0 = fade to silence.
- `vol_target`  in  VOL_BITS  requested volume. Unsigned; 0 = silent.
- `snd_out`  out  1  sigma-delta audio to the pad. Registered.
- `level`  out  DEC_LOG2+1  last completed window's count of ones in `snd_in` (0..W).
- `fading`  out  1  high while the volume is slewing.
- `muted`  out  1  high in IDLE.

## Operation
- Density measurement:
  - `wcnt` (DEC_LOG2 bits) increments every cycle and wraps from W-1 to 0.
  - `acc` (DEC_LOG2+1 bits) adds `snd_in` each cycle.
  - On the cycle where `wcnt == W-1`: `level <= acc + snd_in`, and `acc <= 0`.
  - `acc` and `level` never saturate, because the maximum count is W.
- Volume target: `goal = enable ? vol_target : 0`. It is evaluated every cycle.
- Volume register `cur_vol` (VOL_BITS bits) is controlled by a state machine:
  - IDLE: `cur_vol == 0`, `goal == 0`. Modulator accumulator `sd` is held at 0; `snd_out` is 0. If `goal != 0`, go to SLEW.
  - SLEW: fade timer `ft` (FADE_LOG2 bits) increments each cycle.
    - When `ft` reaches all-ones, `cur_vol` moves exactly 1 toward `goal`, and `ft` wraps to 0.
    - The state is re-evaluated in the following cycle: if `cur_vol == goal == 0`, go to IDLE; if `cur_vol == goal != 0`, go to STEADY.
  - STEADY: `cur_vol == goal != 0`. If `goal` changes (either `enable` falls or `vol_target` changes), go to SLEW.
  - `ft` is cleared on every entry to SLEW.
  - A `goal` change during SLEW does not restart `ft`; the direction of the next step simply follows the new `goal`.
- Modulator:
  - `prod = level * cur_vol`, width DEC_LOG2+VOL_BITS+1. Its maximum is W·(2^VOL_BITS−1), which is below 2^(DEC_LOG2+VOL_BITS).
  - Each cycle outside IDLE: `{carry, sd} <= sd + prod`, with `sd` DEC_LOG2+VOL_BITS bits wide, and `snd_out <= carry`.
  - Long-run `snd_out` density equals level·cur_vol / 2^(DEC_LOG2+VOL_BITS).
- Outputs: `fading = (state == SLEW)`; `muted = (state == IDLE)`.

## Timing
- Reset values (asserted asynchronously, released synchronously to `clk` by the top level):
  - `state` = IDLE; `cur_vol` = 0; `ft` = 0; `wcnt` = 0; `acc` = 0; `level` = 0; `sd` = 0.
  - `snd_out` = 0; `fading` = 0; `muted` = 1.
- Reset mid-operation: all state returns to the values above immediately. No fade-out is performed.
- `level` is valid from the cycle after `wcnt == W-1`. The first update happens W cycles after reset release.
- Enable to first audible output:
  - IDLE→SLEW takes 1 cycle.
  - The first `cur_vol` step is 2^FADE_LOG2 cycles after SLEW entry.
  - `snd_out` can first be 1 on the cycle after `prod` becomes nonzero.
- A full fade from 0 to `vol_target = V` takes V·2^FADE_LOG2 cycles (±1 cycle for the state transition).
- Entering IDLE clears `sd` in the same cycle, so there is no residual tail on re-enable.
- If `enable` falls while in IDLE, or `vol_target = 0` with `enable = 1`, the block stays in IDLE.

## Test plan
- Reset/idle: hold `rst_n = 0` with random `snd_in`, then release with `enable = 0` for 10·W cycles.
  - Required: `snd_out == 0` and `muted == 1` throughout; `level` tracks the density of `snd_in`.
- Density measurement: `snd_in` = 1 for 8 of every 32 cycles, W = 32.
  - Required: `level == 8` after every window. `snd_in` held at 1 gives `level == 32`, with no overflow.
- Fade in: FADE_LOG2 = 4, `vol_target = 15`, raise `enable`, `snd_in` constant 1.
  - Required: `cur_vol` increments every 16 cycles to 15; `fading` is high for about 240 cycles; then STEADY.
  - Over 1024 cycles, the count of 1s in `snd_out` is 32·15/512·1024 = 960 ±1.
- Fade out: from STEADY at volume 15, drop `enable`.
  - Required: `cur_vol` decrements every 16 cycles; IDLE is reached at 0; `sd` is cleared; `muted` goes to 1; `snd_out` stays 0 afterwards.
- Target change mid-slew: during the fade-in at `cur_vol = 6`, set `vol_target = 3`.
  - Required: the next step goes to 5, then 4, then 3; then STEADY. `ft` is not restarted by the change.
- Asynchronous reset during SLEW: pull `rst_n` low between clock edges.
  - Required: outputs go to their reset values without waiting for a clock edge; after release, `muted == 1`.
